// File: rtl/cic_pkg.sv
// Shared CIC constants and helpers used by the interpolator and decimator.
package cic_pkg;

    localparam int N_STAGES       = 3;
    localparam int MAX_LOG2_R     = 4;
    localparam int DEF_WIDTH      = 16;
    localparam int DEF_BIT_GROWTH = 12;
    localparam int DEF_W          = DEF_WIDTH + DEF_BIT_GROWTH;
    localparam int PH_BITS        = MAX_LOG2_R;

    typedef logic [PH_BITS-1:0] phase_t;
    typedef logic [2:0]         log2r_t;

    function automatic log2r_t clamp_k(input log2r_t k);
        return (k > log2r_t'(MAX_LOG2_R)) ? log2r_t'(MAX_LOG2_R) : k;
    endfunction

endpackage

// File: rtl/cic_phase_ctrl.sv
// Low-rate slot sequencing: phase counter, rate latch, handshake, underrun.
module cic_phase_ctrl
    import cic_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   bypass,
    input  log2r_t factor,
    input  logic   x_valid,
    output phase_t ph,
    output log2r_t k_reg,
    output logic   slot,
    output logic   accept,
    output logic   x_ready,
    output logic   underrun
);

    log2r_t               k_new;
    logic [PH_BITS:0]     r_cur;
    phase_t               ph_last;

    assign k_new   = clamp_k(factor);
    assign r_cur   = (PH_BITS+1)'(1) << k_reg;
    assign ph_last = PH_BITS'(r_cur - 1'b1);

    assign slot    = en && !bypass && (ph == '0);
    assign accept  = slot && x_valid;
    assign x_ready = bypass || (en && (ph == '0));

    // The period that starts at ph==0 already runs at the newly latched rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph       <= '0;
            k_reg    <= '0;
            underrun <= 1'b0;
        end else if (bypass) begin
            ph <= '0;
        end else if (en) begin
            if (ph == '0) begin
                k_reg <= k_new;
                ph    <= (k_new == '0) ? phase_t'(0) : phase_t'(1);
                if (!x_valid)
                    underrun <= 1'b1;
            end else begin
                ph <= (ph == ph_last) ? phase_t'(0) : ph + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cic_interpolator.sv
// Three-stage CIC interpolator, R = 2^k (k <= 4), unity DC gain.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int BIT_GROWTH = DEF_BIT_GROWTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic             bypass,
    input  logic [2:0]       Interpolation_Factor,
    input  logic [WIDTH-1:0] x_n,
    input  logic             x_valid,
    output logic             x_ready,
    output logic [WIDTH-1:0] y_n,
    output logic             y_valid,
    output logic             underrun
);

    localparam int W = WIDTH + BIT_GROWTH;

    phase_t            ph;
    log2r_t            k_reg;
    logic              slot;
    logic              accept;
    logic              y_valid_q;
    logic [W-1:0]      x_ext;
    logic [W-1:0]      c     [N_STAGES+1];
    logic [W-1:0]      d     [N_STAGES];
    logic [W-1:0]      integ [N_STAGES];
    logic [W-1:0]      u;
    logic [WIDTH-1:0]  y_dp;

    cic_phase_ctrl u_phase (
        .clk      (clk),
        .rst      (rst),
        .en       (EN),
        .bypass   (bypass),
        .factor   (Interpolation_Factor),
        .x_valid  (x_valid),
        .ph       (ph),
        .k_reg    (k_reg),
        .slot     (slot),
        .accept   (accept),
        .x_ready  (x_ready),
        .underrun (underrun)
    );

    assign x_ext = accept ? {{BIT_GROWTH{x_n[WIDTH-1]}}, x_n} : '0;
    assign c[0]  = x_ext;

    for (genvar s = 0; s < N_STAGES; s++) begin : g_comb
        assign c[s+1] = c[s] - d[s];
    end

    // A missed slot still clocks the combs, with zero as the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < N_STAGES; s++)
                d[s] <= '0;
        end else if (slot) begin
            for (int s = 0; s < N_STAGES; s++)
                d[s] <= c[s];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            u <= '0;
            for (int s = 0; s < N_STAGES; s++)
                integ[s] <= '0;
        end else if (EN && !bypass) begin
            u        <= (ph == '0) ? c[N_STAGES] : '0;
            integ[0] <= integ[0] + u;
            for (int s = 1; s < N_STAGES; s++)
                integ[s] <= integ[s] + integ[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            y_valid_q <= 1'b0;
        else
            y_valid_q <= EN;
    end

    // Gain is R^2, so drop 2k LSBs of the last integrator.
    assign y_dp    = WIDTH'(integ[N_STAGES-1] >> {k_reg, 1'b0});
    assign y_n     = bypass ? x_n : y_dp;
    assign y_valid = bypass ? x_valid : y_valid_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed checks for cic_interpolator with hand-derived expected values.
module tb_cic_interpolator;

    logic               clk = 1'b0;
    logic               rst;
    logic               EN;
    logic               bypass;
    logic [2:0]         factor;
    logic signed [15:0] x_n;
    logic               x_valid;
    logic               x_ready;
    logic signed [15:0] y_n;
    logic               y_valid;
    logic               underrun;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cic_interpolator dut (
        .clk                  (clk),
        .rst                  (rst),
        .EN                   (EN),
        .bypass               (bypass),
        .Interpolation_Factor (factor),
        .x_n                  (x_n),
        .x_valid              (x_valid),
        .x_ready              (x_ready),
        .y_n                  (y_n),
        .y_valid              (y_valid),
        .underrun             (underrun)
    );

    task automatic check(input string tag,
                         input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        EN      = 1'b0;
        bypass  = 1'b0;
        x_valid = 1'b1;
        x_n     = '0;
        tick(2);
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!x_ready && n < 40) begin
            tick();
            n++;
        end
        check("wait_ready", x_ready, 1);
    endtask

    initial begin
        int cnt;
        int n;
        logic dev;

        // Reset state
        factor = 3'd0;
        do_reset();
        check("rst_y", y_n, 0);
        check("rst_yv", y_valid, 0);
        check("rst_ur", underrun, 0);
        check("rst_rdy_en0", x_ready, 0);

        // Impulse, k=0: single 1 reaches y four cycles after accept
        EN = 1'b1;
        tick(3);
        x_n = 16'sd1;
        #1;
        check("imp_rdy", x_ready, 1);
        check("imp_y0", y_n, 0);
        for (int off = 1; off <= 8; off++) begin
            tick();
            x_n = '0;
            check($sformatf("imp_y%0d", off), y_n, (off == 4) ? 1 : 0);
        end
        check("imp_yv", y_valid, 1);

        // Same impulse with a 5-cycle EN freeze after two EN cycles
        do_reset();
        EN = 1'b1;
        tick(2);
        x_n = 16'sd1;
        tick();
        x_n = '0;
        tick();
        EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("frz_yv", y_valid, 0);
            check("frz_y", y_n, 0);
        end
        check("frz_ur", underrun, 0);
        EN = 1'b1;
        tick();
        check("frz_y3", y_n, 0);
        tick();
        check("frz_y4", y_n, 1);
        check("frz_yv4", y_valid, 1);
        tick();
        check("frz_y5", y_n, 0);

        // DC, k=2: one slot in four, output settles to the input
        factor = 3'd2;
        do_reset();
        x_n = 16'sd1000;
        EN  = 1'b1;
        #1;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (x_ready) cnt++;
            tick();
        end
        check("dc_rdy_cnt", cnt, 4);
        tick(20);
        for (int i = 0; i < 4; i++) begin
            check("dc_y", y_n, 1000);
            tick();
        end

        // Bypass: combinational passthrough, datapath state retained
        bypass = 1'b1;
        x_n    = -16'sd7;
        #1;
        check("byp_y", y_n, -7);
        check("byp_rdy", x_ready, 1);
        check("byp_yv", y_valid, 1);
        x_valid = 1'b0;
        #1;
        check("byp_yv0", y_valid, 0);
        tick(3);
        check("byp_y_hold", y_n, -7);
        bypass  = 1'b0;
        x_valid = 1'b1;
        x_n     = 16'sd1000;
        #1;
        check("byp_ret_y", y_n, 1000);
        check("byp_ret_rdy", x_ready, 1);
        tick(8);
        check("byp_ret_y8", y_n, 1000);
        check("byp_ur", underrun, 0);

        // Underrun, k=3: missed slot sets the sticky flag
        factor = 3'd3;
        do_reset();
        x_n = 16'sd1000;
        EN  = 1'b1;
        tick(80);
        check("ur_pre_y", y_n, 1000);
        check("ur_pre", underrun, 0);
        wait_ready();
        x_valid = 1'b0;
        tick();
        x_valid = 1'b1;
        check("ur_set", underrun, 1);
        dev = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (y_n != 16'sd1000) dev = 1'b1;
            tick();
        end
        check("ur_transient", dev, 1);
        tick(40);
        check("ur_post_y", y_n, 1000);
        check("ur_sticky", underrun, 1);

        // Reset mid-period clears everything, first accept at ph==0
        wait_ready();
        tick();
        check("mid_rdy", x_ready, 0);
        rst = 1'b1;
        EN  = 1'b0;
        tick();
        check("mid_y", y_n, 0);
        check("mid_yv", y_valid, 0);
        check("mid_ur", underrun, 0);
        check("mid_rdy_rst", x_ready, 0);
        rst = 1'b0;
        EN  = 1'b1;
        #1;
        check("mid_first_rdy", x_ready, 1);

        // Factor change k 1->4 mid-period
        factor = 3'd1;
        do_reset();
        x_n = '0;
        EN  = 1'b1;
        tick(10);
        wait_ready();
        tick();
        factor = 3'd4;
        #1;
        check("fc_mid_rdy", x_ready, 0);
        tick();
        check("fc_sp2", x_ready, 1);
        tick();
        n = 1;
        while (!x_ready && n < 40) begin
            tick();
            n++;
        end
        check("fc_sp16", n, 16);
        x_n = 16'sd500;
        tick(150);
        check("fc_dc", y_n, 500);
        tick();
        check("fc_dc2", y_n, 500);

        // k above 4 behaves as 4
        factor = 3'd7;
        wait_ready();
        tick();
        n = 1;
        while (!x_ready && n < 40) begin
            tick();
            n++;
        end
        check("k7_sp16", n, 16);
        tick(3);
        check("k7_dc", y_n, 500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
